// File: rtl/semaforo_monitor_pkg.sv
// Shared constants for the semaforo light monitor: one-hot colours, checker states and
// error codes, plus small helpers for colour decoding and legal sequencing.
package semaforo_monitor_pkg;

  localparam logic [2:0] COR_VERDE    = 3'b001;
  localparam logic [2:0] COR_AMARELO  = 3'b010;
  localparam logic [2:0] COR_VERMELHO = 3'b100;

  localparam logic [1:0] ST_INIT      = 2'd0;
  localparam logic [1:0] ST_VERDE     = 2'd1;
  localparam logic [1:0] ST_AMARELO   = 2'd2;
  localparam logic [1:0] ST_VERMELHO  = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
  localparam logic [2:0] ERR_CONFLICT = 3'd2;
  localparam logic [2:0] ERR_ORDER    = 3'd3;
  localparam logic [2:0] ERR_VERDE_T  = 3'd4;
  localparam logic [2:0] ERR_AMAR_T   = 3'd5;
  localparam logic [2:0] ERR_VERM_T   = 3'd6;

  function automatic logic is_onehot(input logic [2:0] cor);
    return (cor == COR_VERDE) || (cor == COR_AMARELO) || (cor == COR_VERMELHO);
  endfunction

  // Non one-hot values map to ST_INIT; callers screen them out first.
  function automatic logic [1:0] cor_to_st(input logic [2:0] cor);
    case (cor)
      COR_VERDE:    return ST_VERDE;
      COR_AMARELO:  return ST_AMARELO;
      COR_VERMELHO: return ST_VERMELHO;
      default:      return ST_INIT;
    endcase
  endfunction

  function automatic logic [1:0] next_st(input logic [1:0] st);
    case (st)
      ST_VERDE:    return ST_AMARELO;
      ST_AMARELO:  return ST_VERMELHO;
      ST_VERMELHO: return ST_VERDE;
      default:     return ST_INIT;
    endcase
  endfunction

endpackage

// File: rtl/semaforo_light_checker.sv
// Per-light phase tracker: follows the colour sequence and dwell time of one light and
// raises single-cycle flags for illegal encodings, bad order and bad durations.
module semaforo_light_checker
  import semaforo_monitor_pkg::*;
#(
  parameter logic [7:0] VERDE      = 8'd3,
  parameter logic [7:0] AMARELO    = 8'd1,
  parameter logic [7:0] VERMELHO   = 8'd2,
  parameter bit         CHECK_VERM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] luz,
  output logic       illegal,
  output logic       order,
  output logic       verde_t,
  output logic       amar_t,
  output logic       verm_t,
  output logic       round
);

  logic [1:0] st_q, st_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] dwell_inc;
  logic [1:0] cor_st;

  always_comb begin
    st_d      = st_q;
    dwell_d   = dwell_q;
    order     = 1'b0;
    verde_t   = 1'b0;
    amar_t    = 1'b0;
    verm_t    = 1'b0;
    round     = 1'b0;
    illegal   = !is_onehot(luz);
    cor_st    = cor_to_st(luz);
    dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;

    if (illegal) begin
      // Garbage sample: keep phase and dwell exactly as they were.
    end else if (st_q == ST_INIT) begin
      st_d    = cor_st;
      dwell_d = 8'd1;
    end else if (cor_st == st_q) begin
      dwell_d = dwell_inc;
      verde_t = (st_q == ST_VERDE)   && ({1'b0, dwell_inc} == {1'b0, VERDE} + 9'd1);
      amar_t  = (st_q == ST_AMARELO) && ({1'b0, dwell_inc} == {1'b0, AMARELO} + 9'd1);
    end else begin
      order   = (cor_st != next_st(st_q));
      amar_t  = (st_q == ST_AMARELO) && (dwell_q < AMARELO);
      verm_t  = CHECK_VERM && (st_q == ST_VERMELHO) && (dwell_q < VERMELHO);
      round   = (st_q == ST_VERMELHO) && (cor_st == ST_VERDE);
      st_d    = cor_st;
      dwell_d = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_INIT;
      dwell_q <= 8'd0;
    end else begin
      st_q    <= st_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker for the two semaforo lights: conflict detection, priority encoding of
// violations, first-error latch, cycle counter and completed A rounds.
module semaforo_monitor
  import semaforo_monitor_pkg::*;
#(
  parameter logic [7:0] VERDE    = 8'd3,
  parameter logic [7:0] AMARELO  = 8'd1,
  parameter logic [7:0] VERMELHO = 8'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        err_light,
  output logic [15:0] err_cycle,
  output logic [7:0]  ciclos_a
);

  logic ill_a, ord_a, vt_a, at_a, mt_a, round_a;
  logic ill_b, ord_b, vt_b, at_b, unused_verm_b, unused_round_b;
  logic conflict;
  logic [2:0] code_d;
  logic light_d;
  logic [15:0] cyc_q;

  semaforo_light_checker #(
    .VERDE(VERDE), .AMARELO(AMARELO), .VERMELHO(VERMELHO), .CHECK_VERM(1'b1)
  ) u_chk_a (
    .clk(clk), .rst(rst), .luz(A), .illegal(ill_a), .order(ord_a), .verde_t(vt_a),
    .amar_t(at_a), .verm_t(mt_a), .round(round_a)
  );

  semaforo_light_checker #(
    .VERDE(VERDE), .AMARELO(AMARELO), .VERMELHO(VERMELHO), .CHECK_VERM(1'b0)
  ) u_chk_b (
    .clk(clk), .rst(rst), .luz(B), .illegal(ill_b), .order(ord_b), .verde_t(vt_b),
    .amar_t(at_b), .verm_t(unused_verm_b), .round(unused_round_b)
  );

  assign conflict = (A != COR_VERMELHO) && (B != COR_VERMELHO);

  // Lowest code wins; within a code, light A beats light B.
  always_comb begin
    code_d  = ERR_NONE;
    light_d = 1'b0;
    if      (ill_a)    code_d = ERR_ILLEGAL;
    else if (ill_b)    begin code_d = ERR_ILLEGAL; light_d = 1'b1; end
    else if (conflict) code_d = ERR_CONFLICT;
    else if (ord_a)    code_d = ERR_ORDER;
    else if (ord_b)    begin code_d = ERR_ORDER;   light_d = 1'b1; end
    else if (vt_a)     code_d = ERR_VERDE_T;
    else if (vt_b)     begin code_d = ERR_VERDE_T; light_d = 1'b1; end
    else if (at_a)     code_d = ERR_AMAR_T;
    else if (at_b)     begin code_d = ERR_AMAR_T;  light_d = 1'b1; end
    else if (mt_a)     code_d = ERR_VERM_T;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= 16'd0;
      ciclos_a  <= 8'd0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      err_light <= 1'b0;
      err_cycle <= 16'd0;
    end else begin
      if (cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
      if (round_a) ciclos_a <= ciclos_a + 8'd1;
      if (!err && (code_d != ERR_NONE)) begin
        err       <= 1'b1;
        err_code  <= code_d;
        err_light <= light_d;
        err_cycle <= cyc_q;
      end
    end
  end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: each step queues its expected outputs, clocks one
// sample through the DUT and compares against the popped expectation.
module tb_semaforo_monitor;

  localparam logic [2:0] V  = 3'b001;
  localparam logic [2:0] AM = 3'b010;
  localparam logic [2:0] R  = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B;
  logic        err;
  logic [2:0]  err_code;
  logic        err_light;
  logic [15:0] err_cycle;
  logic [7:0]  ciclos_a;

  always #5 clk = ~clk;

  semaforo_monitor dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .err(err), .err_code(err_code),
    .err_light(err_light), .err_cycle(err_cycle), .ciclos_a(ciclos_a)
  );

  typedef struct {
    string       tag;
    logic        err;
    logic [2:0]  code;
    logic        light;
    logic [15:0] cyc;
    logic [7:0]  cic;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string what, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", what, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b,
                      input logic e, input logic [2:0] code, input logic lt,
                      input logic [15:0] ec, input logic [7:0] cic, input string tag);
    exp_t x;
    x.tag = tag; x.err = e; x.code = code; x.light = lt; x.cyc = ec; x.cic = cic;
    sb.push_back(x);
    rst = r; A = a; B = b;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, ".err"},       {15'd0, err},       {15'd0, x.err});
    check({x.tag, ".err_code"},  {13'd0, err_code},  {13'd0, x.code});
    check({x.tag, ".err_light"}, {15'd0, err_light}, {15'd0, x.light});
    check({x.tag, ".err_cycle"}, err_cycle,          x.cyc);
    check({x.tag, ".ciclos_a"},  {8'd0, ciclos_a},   {8'd0, x.cic});
  endtask

  task automatic ok(input logic [2:0] a, input logic [2:0] b, input logic [7:0] cic,
                    input string tag);
    step(1'b0, a, b, 1'b0, 3'd0, 1'b0, 16'd0, cic, tag);
  endtask

  task automatic do_reset(input logic [2:0] a, input logic [2:0] b, input string tag);
    step(1'b1, a, b, 1'b0, 3'd0, 1'b0, 16'd0, 8'd0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; A = 3'b000; B = 3'b000;

    // Reset with junk on the lights.
    do_reset(3'b011, 3'b000, "rst0");
    do_reset(3'b111, 3'b001, "rst1");

    // Nominal rounds, green exactly VERDE, then green too long, then a round after the error.
    ok(V, R, 0, "nom0");  ok(V, R, 0, "nom1");  ok(V, R, 0, "nom2");
    ok(AM, R, 0, "nom3"); ok(R, R, 0, "nom4");  ok(R, R, 0, "nom5");
    ok(V, R, 1, "nom6");  ok(V, R, 1, "nom7");  ok(V, R, 1, "nom8");
    ok(AM, R, 1, "nom9"); ok(R, R, 1, "nom10"); ok(R, R, 1, "nom11");
    ok(V, R, 2, "nom12"); ok(V, R, 2, "nom13"); ok(V, R, 2, "nom14");
    step(1'b0, V,  R, 1'b1, 3'd4, 1'b0, 16'd15, 8'd2, "vlong15");
    step(1'b0, AM, R, 1'b1, 3'd4, 1'b0, 16'd15, 8'd2, "vlong16");
    step(1'b0, R,  R, 1'b1, 3'd4, 1'b0, 16'd15, 8'd2, "vlong17");
    step(1'b0, R,  R, 1'b1, 3'd4, 1'b0, 16'd15, 8'd2, "vlong18");
    step(1'b0, V,  R, 1'b1, 3'd4, 1'b0, 16'd15, 8'd3, "vlong19");

    // Short green is fine; yellow held two cycles is not.
    do_reset(V, R, "rst_t3");
    ok(V, R, 0, "amar0"); ok(AM, R, 0, "amar1");
    step(1'b0, AM, R, 1'b1, 3'd5, 1'b0, 16'd2, 8'd0, "amar2");

    // Illegal B and conflict in the same cycle: illegal wins, blamed on B.
    do_reset(R, R, "rst_t4");
    ok(R, R, 0, "ill0"); ok(R, R, 0, "ill1"); ok(R, R, 0, "ill2");
    ok(R, R, 0, "ill3"); ok(R, R, 0, "ill4");
    step(1'b0, V, 3'b011, 1'b1, 3'd1, 1'b1, 16'd5, 8'd1, "ill5");

    // Pure conflict.
    do_reset(R, R, "rst_conf");
    step(1'b0, V, V, 1'b1, 3'd2, 1'b0, 16'd0, 8'd0, "conf0");

    // Order error on light B.
    do_reset(R, R, "rst_ordb");
    ok(R, V, 0, "ordb0");
    step(1'b0, R, R, 1'b1, 3'd3, 1'b1, 16'd1, 8'd0, "ordb1");

    // Order error on A, later violations ignored, round still counted.
    do_reset(R, R, "rst_t5");
    ok(V, R, 0, "orda0"); ok(V, R, 0, "orda1"); ok(V, R, 0, "orda2");
    step(1'b0, R,      R, 1'b1, 3'd3, 1'b0, 16'd3, 8'd0, "orda3");
    step(1'b0, 3'b011, R, 1'b1, 3'd3, 1'b0, 16'd3, 8'd0, "orda4");
    step(1'b0, V,      V, 1'b1, 3'd3, 1'b0, 16'd3, 8'd1, "orda5");

    // Reset mid-run clears the latch; no false order error across reset.
    do_reset(V, V, "rst_t6");
    ok(R, R, 0, "rr0"); ok(R, R, 0, "rr1"); ok(V, R, 1, "rr2");

    // Light A leaves red too early.
    do_reset(R, R, "rst_verm");
    ok(R, R, 0, "verm0");
    step(1'b0, V, R, 1'b1, 3'd6, 1'b0, 16'd1, 8'd1, "verm1");

    // Light B leaving red early is not a violation.
    do_reset(R, R, "rst_bred");
    ok(R, R, 0, "bred0"); ok(R, V, 0, "bred1"); ok(R, AM, 0, "bred2");
    ok(R, R, 0, "bred3"); ok(V, R, 1, "bred4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
